log_offset_lut_pipe: RTL

LOG_OFFSET_LUT_PIPE -- requirements
Module: log_offset_lut_pipe

---
 rtl/log_offset_lut_pipe.sv | 97 +++++++++
 1 files changed

// File: rtl/log_offset_lut_pipe.sv
// Purpose : per-lane lookup of log offsets from a small writable register table.
// Latency : 2 cycles from request acceptance to out_valid; one result per cycle.
// Backpr. : out_ready=0 with a result held stalls both stages; in_ready drops only then.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake, in_idx = LANES packed IDX_W indices
//   out_valid/out_ready     result handshake, out_data = LANES packed DATA_W entries
//   wr_en/wr_addr/wr_data   table write port, commits on any edge with wr_en=1
//   lookup_cnt              wrapping count of delivered results
//
// Optional build macro: LOG_OFFSET_WR_BYPASS_EN -- forward a same-edge table write
// to any lane whose S1 index matches the write address.
module log_offset_lut_pipe #(
  parameter int                IDX_W       = 4,
  parameter int                DATA_W      = 24,
  parameter int                LANES       = 1,
  parameter logic [DATA_W-1:0] DEFAULT_VAL = DATA_W'(24'h100100)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*IDX_W-1:0]    in_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [15:0]               lookup_cnt
);

  localparam int DEPTH = 2**IDX_W;

  logic [DATA_W-1:0]       lut_q [DEPTH];
  logic                    s1_valid;
  logic [LANES*IDX_W-1:0]  s1_idx;
  logic                    s2_valid;
  logic [LANES*DATA_W-1:0] s2_data;
  logic [LANES*DATA_W-1:0] s2_next;
  logic                    advance;

  // The whole pipe moves as one unit whenever the output slot is free or draining.
  assign advance   = !s2_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;

  // Table: entries 0 and 1 come up as zero, the rest as DEFAULT_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        lut_q[i] <= (i < 2) ? '0 : DEFAULT_VAL;
      end
    end else if (wr_en) begin
      lut_q[wr_addr] <= wr_data;
    end
  end

  // Per-lane read of the S1 index. lut_q holds the pre-write value on the
  // edge a write commits, so without forwarding the older entry is seen.
  always_comb begin
    s2_next = '0;
    for (int k = 0; k < LANES; k++) begin
      s2_next[k*DATA_W +: DATA_W] = lut_q[s1_idx[k*IDX_W +: IDX_W]];
`ifdef LOG_OFFSET_WR_BYPASS_EN
      if (wr_en && (wr_addr == s1_idx[k*IDX_W +: IDX_W])) begin
        s2_next[k*DATA_W +: DATA_W] = wr_data;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_data  <= s2_next;
      s1_valid <= in_valid;
      s1_idx   <= in_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_cnt <= 16'd0;
    end else if (s2_valid && out_ready) begin
      lookup_cnt <= lookup_cnt + 16'd1;
    end
  end

endmodule
